// File: rtl/dout_pwm_bank_pkg.sv
// dout_pwm_bank_pkg: register map constants and channel state type for the DOUT PWM bank
package dout_pwm_bank_pkg;
  localparam logic [3:0] ADDR_MAIN     = 4'h2;
  localparam logic [3:0] REG_DIGIOUT   = 4'h0;
  localparam logic [3:0] OFF_DOUT_CTRL = 4'h1;
  localparam logic [3:0] OFF_DOUT_CNT  = 4'h2;
  typedef enum logic [1:0] {ST_STATIC, ST_TIMING, ST_DONE} chan_state_t;
endpackage

// File: rtl/dout_pwm_chan.sv
// dout_pwm_chan: one digital-output channel with exact-cycle high/low timing, pulse counting
// and period-boundary shadow updates
module dout_pwm_chan
  import dout_pwm_bank_pkg::*;
#(
  parameter int TIME_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              set_en,
  input  logic              set_val,
  input  logic              ctrl_en,
  input  logic              cnt_en,
  input  logic [TIME_W-1:0] hi_in,
  input  logic [TIME_W-1:0] lo_in,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              dout_invert,
  output logic              dout_raw,
  output logic              dout,
  output logic              busy,
  output logic [TIME_W-1:0] sh_hi,
  output logic [TIME_W-1:0] sh_lo,
  output logic [CNT_W-1:0]  count,
  output logic [CNT_W-1:0]  remaining
);
  chan_state_t state, n_state;
  logic [TIME_W-1:0] timer, hi, lo, t_act, n_timer, n_hi, n_lo, n_sh_hi, n_sh_lo;
  logic [CNT_W-1:0] n_count, n_rem;
  logic pend, n_pend, n_raw, n_done, running, toggle;
  assign busy = state == ST_TIMING;
  always_comb begin
    t_act = dout_raw ? hi : lo;
    running = state == ST_TIMING && hi != '0 && lo != '0;
    toggle = state == ST_TIMING && timer == t_act - 1'b1;
    n_raw = dout_raw;
    n_timer = timer;
    n_hi = hi;
    n_lo = lo;
    n_sh_hi = sh_hi;
    n_sh_lo = sh_lo;
    n_pend = pend;
    n_count = count;
    n_rem = remaining;
    n_done = state == ST_DONE;
    if (pend && !running) begin
      n_hi = sh_hi;
      n_lo = sh_lo;
      n_timer = '0;
      n_pend = 1'b0;
    end else if (toggle) begin
      n_raw = !dout_raw;
      n_timer = '0;
      // a pending shadow lands only at period start, so the running period never gets a runt
      if (!dout_raw && pend) begin
        n_hi = sh_hi;
        n_lo = sh_lo;
        n_pend = 1'b0;
      end
      if (dout_raw && running && count != '0) begin
        n_done = remaining <= CNT_W'(1);
        n_rem = n_done ? '0 : remaining - 1'b1;
      end
    end else if (state == ST_TIMING) begin
      n_timer = timer + 1'b1;
    end
    if (cnt_en) begin
      n_count = cnt_in;
      n_rem = cnt_in;
    end
    if (ctrl_en) begin
      n_sh_hi = hi_in;
      n_sh_lo = lo_in;
      n_pend = running;
      n_hi = running ? n_hi : hi_in;
      n_lo = running ? n_lo : lo_in;
      n_timer = running ? n_timer : '0;
      n_done = running ? n_done : 1'b0;
    end
    if (set_en) begin
      n_raw = set_val;
      n_timer = '0;
      n_rem = count;
      n_done = 1'b0;
    end
    n_state = n_done ? ST_DONE : ((n_raw ? n_hi : n_lo) != '0 ? ST_TIMING : ST_STATIC);
  end
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= ST_STATIC;
      timer <= '0;
      hi <= '0;
      lo <= '0;
      sh_hi <= '0;
      sh_lo <= '0;
      pend <= 1'b0;
      count <= '0;
      remaining <= '0;
      dout_raw <= 1'b0;
      dout <= 1'b0;
    end else begin
      state <= n_state;
      timer <= n_timer;
      hi <= n_hi;
      lo <= n_lo;
      sh_hi <= n_sh_hi;
      sh_lo <= n_sh_lo;
      pend <= n_pend;
      count <= n_count;
      remaining <= n_rem;
      dout_raw <= n_raw;
      dout <= n_raw ^ dout_invert;
    end
  end
endmodule

// File: rtl/dout_pwm_bank.sv
// dout_pwm_bank: register decode, per-channel instances and read mux for the DOUT PWM bank
module dout_pwm_bank
  import dout_pwm_bank_pkg::*;
#(
  parameter int NUM_DOUT = 4,
  parameter int TIME_W   = 16,
  parameter int CNT_W    = 16
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic [15:0]         reg_raddr,
  input  logic [15:0]         reg_waddr,
  input  logic [31:0]         reg_wdata,
  input  logic                reg_wen,
  output logic [31:0]         reg_rdata,
  input  logic                dout_invert,
  output logic [NUM_DOUT-1:0] dout,
  output logic [NUM_DOUT-1:0] dout_busy
);
  logic wr, unused_bits;
  logic [NUM_DOUT-1:0] raw;
  logic [TIME_W-1:0] sh_hi [NUM_DOUT];
  logic [TIME_W-1:0] sh_lo [NUM_DOUT];
  logic [CNT_W-1:0] count [NUM_DOUT];
  logic [CNT_W-1:0] remaining [NUM_DOUT];
  assign wr = reg_wen && reg_waddr[15:12] == ADDR_MAIN;
  assign unused_bits = ^{reg_waddr[11:8], reg_raddr[11:8], reg_wdata};
  genvar k;
  for (k = 0; k < NUM_DOUT; k++) begin : g_ch
    dout_pwm_chan #(.TIME_W(TIME_W), .CNT_W(CNT_W)) u_chan (
      .sysclk      (sysclk),
      .reset       (reset),
      .set_en      (wr && reg_waddr[7:0] == {4'h0, REG_DIGIOUT} && reg_wdata[16+k]),
      .set_val     (reg_wdata[k]),
      .ctrl_en     (wr && reg_waddr[7:4] == 4'(k + 1) && reg_waddr[3:0] == OFF_DOUT_CTRL),
      .cnt_en      (wr && reg_waddr[7:4] == 4'(k + 1) && reg_waddr[3:0] == OFF_DOUT_CNT),
      .hi_in       (reg_wdata[16+:TIME_W]),
      .lo_in       (reg_wdata[TIME_W-1:0]),
      .cnt_in      (reg_wdata[CNT_W-1:0]),
      .dout_invert (dout_invert),
      .dout_raw    (raw[k]),
      .dout        (dout[k]),
      .busy        (dout_busy[k]),
      .sh_hi       (sh_hi[k]),
      .sh_lo       (sh_lo[k]),
      .count       (count[k]),
      .remaining   (remaining[k])
    );
  end
  always_comb begin
    reg_rdata = '0;
    if (reg_raddr[15:12] == ADDR_MAIN) begin
      if (reg_raddr[7:0] == {4'h0, REG_DIGIOUT}) reg_rdata = {16'(dout_busy), 16'(raw)};
      for (int i = 0; i < NUM_DOUT; i++)
        if (reg_raddr[7:4] == 4'(i + 1))
          reg_rdata = reg_raddr[3:0] == OFF_DOUT_CTRL ? {16'(sh_hi[i]), 16'(sh_lo[i])} :
                      reg_raddr[3:0] == OFF_DOUT_CNT  ? {16'(remaining[i]), 16'(count[i])} : '0;
    end
  end
endmodule

// File: tb/tb_dout_pwm_bank.sv
// tb_dout_pwm_bank: scoreboard bench for dout_pwm_bank; expected per-cycle outputs are queued
// as stimulus is issued and popped as the DUT produces each cycle
module tb_dout_pwm_bank;
  import dout_pwm_bank_pkg::*;
  logic sysclk = 1'b0, reset = 1'b0, reg_wen = 1'b0, dout_invert = 1'b0;
  logic [15:0] reg_raddr = '0, reg_waddr = '0;
  logic [31:0] reg_wdata = '0, reg_rdata, v;
  logic [3:0] dout, dout_busy;
  typedef struct packed {logic [3:0] mask; logic [3:0] dout; logic [3:0] busy;} exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;

  dout_pwm_bank #(.NUM_DOUT(4), .TIME_W(16), .CNT_W(16)) dut (
    .sysclk(sysclk), .reset(reset), .reg_raddr(reg_raddr), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_rdata(reg_rdata),
    .dout_invert(dout_invert), .dout(dout), .dout_busy(dout_busy)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ad(input logic [3:0] ch, input logic [3:0] off);
    return {ADDR_MAIN, 4'h0, ch, off};
  endfunction

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    reg_waddr = a;
    reg_wdata = d;
    reg_wen = 1'b1;
    @(negedge sysclk);
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] r);
    reg_raddr = a;
    #1;
    r = reg_rdata;
  endtask

  task automatic test_reset;
    @(negedge sysclk);
    total++;
    if (dout !== 4'b0 || dout_busy !== 4'b0) begin
      bad++;
      $display("FAIL reset_outputs dout=%b busy=%b want 0000/0000", dout, dout_busy);
    end
    rd(ad(4'h0, REG_DIGIOUT), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_digiout got %h want 0", v); end
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
  endtask

  task automatic test_set;
    for (int i = 0; i < 101; i++) sb.push_back('{4'hf, 4'b0001, 4'b0000});
    wr(ad(4'h0, REG_DIGIOUT), {16'h0003, 16'h0001});
    for (int i = 0; i < 101; i++) begin
      e = sb.pop_front();
      total++;
      if (((dout ^ e.dout) & e.mask) !== 4'b0 || ((dout_busy ^ e.busy) & e.mask) !== 4'b0) begin
        bad++;
        $display("FAIL set cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_oneshot;
    wr(ad(4'h0, REG_DIGIOUT), {16'h000f, 16'h0000});
    wr(ad(4'h1, OFF_DOUT_CTRL), {16'd5, 16'd0});
    for (int i = 0; i < 10; i++) sb.push_back('{4'hf, {3'b0, i < 5}, {3'b0, i < 5}});
    wr(ad(4'h0, REG_DIGIOUT), {16'h0001, 16'h0001});
    for (int i = 0; i < 10; i++) begin
      e = sb.pop_front();
      total++;
      if (((dout ^ e.dout) & e.mask) !== 4'b0 || ((dout_busy ^ e.busy) & e.mask) !== 4'b0) begin
        bad++;
        $display("FAIL oneshot cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_pulse_train;
    wr(ad(4'h2, OFF_DOUT_CTRL), {16'd3, 16'd2});
    wr(ad(4'h2, OFF_DOUT_CNT), 32'd4);
    for (int i = 0; i < 25; i++)
      sb.push_back('{4'hf, {2'b0, i < 18 && (i % 5) < 3, 1'b0}, {2'b0, i < 18, 1'b0}});
    wr(ad(4'h0, REG_DIGIOUT), {16'h0002, 16'h0002});
    for (int i = 0; i < 25; i++) begin
      e = sb.pop_front();
      total++;
      if (((dout ^ e.dout) & e.mask) !== 4'b0 || ((dout_busy ^ e.busy) & e.mask) !== 4'b0) begin
        bad++;
        $display("FAIL train cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      @(negedge sysclk);
    end
    rd(ad(4'h2, OFF_DOUT_CNT), v);
    total++;
    if (v !== 32'h0000_0004) begin bad++; $display("FAIL train_cnt_readback got %h want 00000004", v); end
    rd(ad(4'h2, OFF_DOUT_CTRL), v);
    total++;
    if (v !== 32'h0003_0002) begin bad++; $display("FAIL train_ctrl_readback got %h want 00030002", v); end
  endtask

  task automatic test_glitch_free;
    wr(ad(4'h3, OFF_DOUT_CTRL), {16'd10, 16'd10});
    for (int i = 0; i < 45; i++)
      sb.push_back('{4'b0100, {1'b0, i < 10 ? 1'b1 : i < 20 ? 1'b0 : ((i - 20) % 20) < 2, 2'b0}, 4'b0100});
    wr(ad(4'h0, REG_DIGIOUT), {16'h0004, 16'h0004});
    for (int i = 0; i < 45; i++) begin
      e = sb.pop_front();
      total++;
      if (((dout ^ e.dout) & e.mask) !== 4'b0 || ((dout_busy ^ e.busy) & e.mask) !== 4'b0) begin
        bad++;
        $display("FAIL glitch cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      if (i == 3) begin
        reg_waddr = ad(4'h3, OFF_DOUT_CTRL);
        reg_wdata = {16'd2, 16'd18};
        reg_wen = 1'b1;
      end
      @(negedge sysclk);
      reg_wen = 1'b0;
    end
    rd(ad(4'h3, OFF_DOUT_CTRL), v);
    total++;
    if (v !== 32'h0002_0012) begin bad++; $display("FAIL glitch_shadow_readback got %h want 00020012", v); end
  endtask

  task automatic test_back_to_back;
    wr(ad(4'h4, OFF_DOUT_CTRL), {16'd4, 16'd4});
    for (int i = 0; i < 20; i++)
      sb.push_back('{4'b1000, {i < 4 ? 1'b1 : ((i - 4) % 8) < 4, 3'b0}, 4'b1000});
    wr(ad(4'h0, REG_DIGIOUT), {16'h0008, 16'h0008});
    for (int i = 0; i < 20; i++) begin
      e = sb.pop_front();
      total++;
      if (((dout ^ e.dout) & e.mask) !== 4'b0 || ((dout_busy ^ e.busy) & e.mask) !== 4'b0) begin
        bad++;
        $display("FAIL collide cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      if (i == 3) begin
        reg_waddr = ad(4'h0, REG_DIGIOUT);
        reg_wdata = {16'h0008, 16'h0008};
        reg_wen = 1'b1;
      end
      @(negedge sysclk);
      reg_wen = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    sb.push_back('{4'hf, 4'b1111, 4'b1111});
    wr(ad(4'h0, REG_DIGIOUT), {16'h000f, 16'h000f});
    e = sb.pop_front();
    total++;
    if (dout !== e.dout || dout_busy !== e.busy) begin
      bad++;
      $display("FAIL reset_mid_pre dout=%b busy=%b want %b/%b", dout, dout_busy, e.dout, e.busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (dout !== 4'b0 || dout_busy !== 4'b0) begin
      bad++;
      $display("FAIL reset_mid_async dout=%b busy=%b want 0000/0000", dout, dout_busy);
    end
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b1;
    rd(ad(4'h0, REG_DIGIOUT), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_mid_digiout got %h want 0", v); end
    for (int c = 1; c <= 4; c++) begin
      rd(ad(4'(c), OFF_DOUT_CTRL), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL reset_mid_ctrl ch%0d got %h want 0", c, v); end
      rd(ad(4'(c), OFF_DOUT_CNT), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL reset_mid_cnt ch%0d got %h want 0", c, v); end
    end
    @(negedge sysclk);
    for (int i = 0; i < 3; i++) sb.push_back('{4'hf, 4'b0000, 4'b0000});
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      total++;
      if (dout !== e.dout || dout_busy !== e.busy) begin
        bad++;
        $display("FAIL reset_mid_idle cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      @(negedge sysclk);
    end
  endtask

  task automatic test_invert;
    dout_invert = 1'b1;
    @(negedge sysclk);
    total++;
    if (dout !== 4'b1111) begin bad++; $display("FAIL invert_idle dout=%b want 1111", dout); end
    rd(ad(4'h0, REG_DIGIOUT), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL invert_idle_raw got %h want 0", v); end
    wr(ad(4'h0, REG_DIGIOUT), {16'h000f, 16'h0005});
    total++;
    if (dout !== 4'b1010 || dout_busy !== 4'b0) begin
      bad++;
      $display("FAIL invert_set dout=%b busy=%b want 1010/0000", dout, dout_busy);
    end
    rd(ad(4'h0, REG_DIGIOUT), v);
    total++;
    if (v !== 32'h0000_0005) begin bad++; $display("FAIL invert_set_raw got %h want 00000005", v); end
    dout_invert = 1'b0;
    @(negedge sysclk);
    total++;
    if (dout !== 4'b0101) begin bad++; $display("FAIL invert_off dout=%b want 0101", dout); end
  endtask

  task automatic test_bad_channel;
    wr(ad(4'h5, OFF_DOUT_CTRL), {16'd7, 16'd7});
    wr(ad(4'h5, OFF_DOUT_CNT), 32'd3);
    wr(ad(4'h0, OFF_DOUT_CTRL), {16'd7, 16'd7});
    rd(ad(4'h5, OFF_DOUT_CTRL), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL badch_ctrl got %h want 0", v); end
    rd(ad(4'h5, OFF_DOUT_CNT), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL badch_cnt got %h want 0", v); end
    rd(ad(4'h0, OFF_DOUT_CTRL), v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL ch0_ctrl got %h want 0", v); end
    for (int c = 1; c <= 4; c++) begin
      rd(ad(4'(c), OFF_DOUT_CTRL), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL badch_alias ch%0d got %h want 0", c, v); end
    end
    for (int i = 0; i < 5; i++) sb.push_back('{4'hf, 4'b0101, 4'b0000});
    for (int i = 0; i < 5; i++) begin
      e = sb.pop_front();
      total++;
      if (dout !== e.dout || dout_busy !== e.busy) begin
        bad++;
        $display("FAIL badch_hold cyc %0d dout=%b busy=%b want %b/%b", i, dout, dout_busy, e.dout, e.busy);
      end
      @(negedge sysclk);
    end
  endtask

  initial begin
    test_reset;
    test_set;
    test_oneshot;
    test_pulse_train;
    test_glitch_free;
    test_back_to_back;
    test_reset_mid;
    test_invert;
    test_bad_channel;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
